// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: data width and word type.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

endpackage : alu_pkg

// File: rtl/nor32_nor_bit.sv
// Single-bit NOR cell; nor32 replicates one per result bit.
module nor_bit (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = ~(a | b);

endmodule : nor_bit

// File: rtl/nor32.sv
// Bitwise NOR unit with a combinational result/zero flag and a 1-cycle registered copy.
module nor32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] out_q,
  output logic             zero_q,
  output logic             out_valid
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nor_bit u_nor_bit (
      .a   (a[i]),
      .b   (b[i]),
      .out (out[i])
    );
  end

  assign zero = (out == '0);

  // Data regs only load on in_valid so the last result survives idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q  <= out;
        zero_q <= zero;
      end
    end
  end

endmodule : nor32

// File: tb/tb_nor32.sv
// Directed self-checking bench for nor32: combinational NOR/zero and the registered stage.
module tb_nor32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] out;
  logic        zero;
  logic [31:0] out_q;
  logic        zero_q;
  logic        out_valid;

  bit run_clk = 1'b0;
  int tests = 0;
  int fails = 0;

  nor32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .zero      (zero),
    .out_q     (out_q),
    .zero_q    (zero_q),
    .out_valid (out_valid)
  );

  // Clock stays idle (clk/rst undriven) until the combinational checks are done.
  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] one;
    in_valid = 1'b0;

    // Reference vector with no clock activity
    a = 32'h42220225; b = 32'h4002028A; #1;
    check("ref_out", out, 32'hBDDDFD50);
    check("ref_zero", {31'd0, zero}, 32'd0);

    a = 32'h00000000; b = 32'h00000000; #1;
    check("zeros_out", out, 32'hFFFFFFFF);
    check("zeros_zero", {31'd0, zero}, 32'd0);

    a = 32'hFFFF0000; b = 32'h0000FFFF; #1;
    check("compl_out", out, 32'h00000000);
    check("compl_zero", {31'd0, zero}, 32'd1);

    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; #1;
    check("ones_out", out, 32'h00000000);
    check("ones_zero", {31'd0, zero}, 32'd1);

    a = 32'h0F0F1234; b = 32'hA0500000; #1;
    check("mixed_out", out, 32'h50A0EDCB);

    for (int i = 0; i < 32; i++) begin
      one = 32'd1;
      a = one << i; b = 32'd0; #1;
      check($sformatf("walk_out_%0d", i), out, ~(one << i));
      check($sformatf("walk_zero_%0d", i), {31'd0, zero}, 32'd0);
    end

    // Registered path
    rst = 1'b1; in_valid = 1'b0; clk = 1'b0; run_clk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_q", out_q, 32'd0);
      check("rst_zero_q", {31'd0, zero_q}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
    end

    rst = 1'b0; in_valid = 1'b1; a = 32'h42220225; b = 32'h4002028A;
    step();
    check("cap_out_q", out_q, 32'hBDDDFD50);
    check("cap_zero_q", {31'd0, zero_q}, 32'd0);
    check("cap_valid", {31'd0, out_valid}, 32'd1);

    in_valid = 1'b0; a = 32'd0; b = 32'd0;
    step();
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_out_q", out_q, 32'hBDDDFD50);
    check("hold_zero_q", {31'd0, zero_q}, 32'd0);

    // Back-to-back captures
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'd0;
    step();
    check("b2b0_out_q", out_q, 32'h00000000);
    check("b2b0_zero_q", {31'd0, zero_q}, 32'd1);
    check("b2b0_valid", {31'd0, out_valid}, 32'd1);
    a = 32'd0; b = 32'd0;
    step();
    check("b2b1_out_q", out_q, 32'hFFFFFFFF);
    check("b2b1_zero_q", {31'd0, zero_q}, 32'd0);
    check("b2b1_valid", {31'd0, out_valid}, 32'd1);

    // Reset priority over in_valid
    rst = 1'b1; in_valid = 1'b1; a = 32'h42220225; b = 32'h4002028A;
    step();
    check("prio_out_q", out_q, 32'd0);
    check("prio_zero_q", {31'd0, zero_q}, 32'd0);
    check("prio_valid", {31'd0, out_valid}, 32'd0);
    check("prio_out", out, 32'hBDDDFD50);

    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_out_q", out_q, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_nor32

// File: doc/nor32.md
Name: nor32

Overview:
- 32-bit bitwise NOR unit for the ALU datapath: out[i] = ~(a[i] | b[i]) for every bit.
- Primary result is purely combinational, with no clock dependency.
- Also provides one optional registered copy of the result, a valid flag and a zero flag, for pipelined consumers in the same clock domain.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥1; all checks use 32.

Ports:
- clk  in  1  system clock; rising edge is active.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_valid  in  1  qualifies a/b for the registered path.
- out  out  WIDTH  combinational result, ~(a | b).
- zero  out  1  combinational flag, high when out == 0.
- out_q  out  WIDTH  registered result.
- zero_q  out  1  registered zero flag.
- out_valid  out  1  high when out_q/zero_q hold a valid result.

Behaviour:
- out is purely combinational: out = ~(a | b), evaluated bitwise.
  - No carries and no dependency between bits.
  - Valid after propagation delay, independent of clk, rst and in_valid.
  - Must also work with clk/rst tied off or left undriven (X/Z); no X on out from clk/rst.
- zero = (out == 0), combinational.
- Registered path, latency 1 cycle:
  - On a rising clk edge with rst=1: out_q <= 0, zero_q <= 0, out_valid <= 0.
  - On a rising clk edge with rst=0 and in_valid=1: out_q <= ~(a|b), zero_q <= zero, out_valid <= 1.
  - On a rising clk edge with rst=0 and in_valid=0: out_q and zero_q hold their previous values; out_valid <= 0.
- Reset values: out_q = 0, zero_q = 0, out_valid = 0.
  - zero_q is deliberately 0 at reset, even though out_q = 0, because it is unqualified.
- Reset asserted together with in_valid=1: reset wins; nothing is captured.
- Back-to-back in_valid: a new result is captured every cycle, at full throughput. There is no backpressure and no stall input.
- No internal state besides the registered path; no FSM.
- No width extension or truncation: all buses are exactly WIDTH bits.

Decomposition:
- Shared package alu_pkg holds:
  - constant DATA_W = 32;
  - typedef word_t = logic [DATA_W-1:0].
- One natural sub-module: nor_bit, a 1-bit cell with out = ~(a|b).
  - nor32 instantiates it WIDTH times via generate.
- The registered stage and the zero flag stay in nor32; no other sub-modules.

Test Plan:
- Reference vector:
  - Stimulus: a = 0x42220225, b = 0x4002028A, wait 100 ps with no clock.
  - Required: out = 0xBDDDFD50 (binary 10111101110111011111110101010000), zero = 0.
- All zeros:
  - Stimulus: a = 0x00000000, b = 0x00000000.
  - Required: out = 0xFFFFFFFF, zero = 0.
- Complementary and all-ones operands:
  - Stimulus: a = 0xFFFF0000, b = 0x0000FFFF.
  - Required: out = 0x00000000, zero = 1.
  - Also required: a = b = 0xFFFFFFFF gives out = 0, zero = 1.
- Walking one:
  - Stimulus: a = 1<<i, b = 0, for i = 0..31.
  - Required: out = ~(1<<i); this checks each bit is independent.
- Registered path:
  - Stimulus: hold rst=1 for 2 cycles, then in_valid=1 with a=0x42220225, b=0x4002028A for one cycle, then in_valid=0.
  - Required: out_valid and out_q stay 0 during reset.
  - Required: one cycle after capture, out_q = 0xBDDDFD50, zero_q = 0, out_valid = 1.
  - Required: the next cycle out_valid = 0 and out_q holds its value.
- Reset priority:
  - Stimulus: rst=1 and in_valid=1 on the same edge.
  - Required: out_q = 0, out_valid = 0.
  - Required: the combinational out still equals ~(a|b) throughout.
